// File: rtl/cache_fill_ctrl_pkg.sv
// Shared types and sizing helpers for the cache miss-fill controller.
// Sizes depend on per-instance parameters, so they are exposed as constant functions.
package cache_fill_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } fill_state_e;

    // OFFSET_W: word-index width within a line.
    function automatic int unsigned calc_offset_w(input int unsigned words_per_line);
        return (words_per_line > 1) ? $clog2(words_per_line) : 1;
    endfunction

    // LINE_BYTES: bytes covered by one cache line.
    function automatic int unsigned calc_line_bytes(input int unsigned words_per_line,
                                                    input int unsigned data_w);
        return words_per_line * (data_w / 8);
    endfunction

    function automatic int unsigned calc_idx_w(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/fixed_prio_arb.sv
// Fixed-priority arbiter: the lowest-index requester wins.
// Produces both a one-hot grant and the encoded winner index.
module fixed_prio_arb
    import cache_fill_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH = 2
) (
    input  logic [NUM_CH-1:0]                 req_i,
    output logic [NUM_CH-1:0]                 gnt_o,
    output logic [calc_idx_w(NUM_CH)-1:0]     idx_o
);

    localparam int unsigned IDX_W = calc_idx_w(NUM_CH);

    // Scan from the top down so the lowest set index is the last write.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache miss-fill controller: arbitrates cache misses, issues one pipelined burst of
// word reads per line and streams the returned words into the owning cache.
module cache_fill_ctrl
    import cache_fill_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned WORDS_PER_LINE = 8,
    parameter int unsigned NUM_CH         = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CH-1:0]                 miss_i,
    input  logic [NUM_CH*ADDR_W-1:0]          miss_addr_i,
    input  logic [DATA_W-1:0]                 mem_data_i,
    input  logic                              mem_valid_i,
    output logic                              mem_en_o,
    output logic [ADDR_W-1:0]                 mem_addr_o,
    output logic [DATA_W-1:0]                 fill_data_o,
    output logic [$clog2(WORDS_PER_LINE)-1:0] fill_offset_o,
    output logic [NUM_CH-1:0]                 fill_we_o,
    output logic [NUM_CH-1:0]                 fill_done_o,
    output logic [ADDR_W-1:0]                 line_addr_o,
    output logic                              busy_o,
    output logic [NUM_CH-1:0]                 stall_o
);

    localparam int unsigned OFFSET_W   = calc_offset_w(WORDS_PER_LINE);
    localparam int unsigned LINE_BYTES = calc_line_bytes(WORDS_PER_LINE, DATA_W);
    localparam int unsigned WORD_BYTES = DATA_W / 8;
    localparam int unsigned CH_W       = calc_idx_w(NUM_CH);

    localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0]   LINE_MASK = ~(ADDR_W'(LINE_BYTES - 1));

    fill_state_e         state_q, state_d;
    logic [CH_W-1:0]     owner_q, owner_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [OFFSET_W-1:0] req_cnt_q, req_cnt_d;
    logic [OFFSET_W-1:0] rsp_cnt_q, rsp_cnt_d;
    logic [NUM_CH-1:0]   fill_done_q, fill_done_d;

    logic [NUM_CH-1:0]   arb_gnt;
    logic [CH_W-1:0]     arb_idx;
    logic                arb_any;
    logic [ADDR_W-1:0]   sel_addr;
    logic [NUM_CH-1:0]   owner_oh;
    logic                req_phase;
    logic                rsp_fire;

    fixed_prio_arb #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req_i (miss_i),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    assign arb_any = |arb_gnt;

    always_comb begin
        sel_addr = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (arb_gnt[c]) begin
                sel_addr = miss_addr_i[c*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        owner_oh = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            owner_oh[c] = (owner_q == CH_W'(c));
        end
    end

    assign req_phase = (state_q == StReq);
    // Responses only count while a fill is collecting data; strays elsewhere are dropped.
    assign rsp_fire  = mem_valid_i && ((state_q == StReq) || (state_q == StWait));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        base_d      = base_q;
        req_cnt_d   = req_cnt_q;
        rsp_cnt_d   = rsp_cnt_q;
        fill_done_d = '0;

        case (state_q)
            StIdle: begin
                if (arb_any) begin
                    state_d   = StReq;
                    owner_d   = arb_idx;
                    base_d    = sel_addr & LINE_MASK;
                    req_cnt_d = '0;
                    rsp_cnt_d = '0;
                end
            end
            StReq: begin
                req_cnt_d = req_cnt_q + OFFSET_W'(1);
                if (req_cnt_q == LAST_WORD) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                state_d = StWait;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // The final response closes the line from either REQ or WAIT.
        if (rsp_fire) begin
            rsp_cnt_d = rsp_cnt_q + OFFSET_W'(1);
            if (rsp_cnt_q == LAST_WORD) begin
                state_d     = StDone;
                fill_done_d = owner_oh;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            base_q      <= '0;
            req_cnt_q   <= '0;
            rsp_cnt_q   <= '0;
            fill_done_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            base_q      <= base_d;
            req_cnt_q   <= req_cnt_d;
            rsp_cnt_q   <= rsp_cnt_d;
            fill_done_q <= fill_done_d;
        end
    end

    always_comb begin
        mem_en_o      = req_phase;
        mem_addr_o    = req_phase ? (base_q + ADDR_W'(req_cnt_q) * ADDR_W'(WORD_BYTES)) : '0;
        fill_data_o   = rsp_fire ? mem_data_i : '0;
        fill_offset_o = rsp_fire ? rsp_cnt_q : '0;
        fill_we_o     = rsp_fire ? owner_oh : '0;
        fill_done_o   = fill_done_q;
        line_addr_o   = (state_q == StDone) ? base_q : '0;
        busy_o        = (state_q != StIdle);
        stall_o       = miss_i & ~fill_done_q;
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: per-cycle expected outputs against a
// fixed/variable-latency memory that returns data equal to the request address.
module tb_cache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  miss_i = '0;
    logic [31:0] miss_addr_i = '0;
    logic [15:0] mem_data_i = '0;
    logic        mem_valid_i = 1'b0;
    logic        mem_en_o;
    logic [15:0] mem_addr_o;
    logic [15:0] fill_data_o;
    logic [1:0]  fill_offset_o;
    logic [1:0]  fill_we_o;
    logic [1:0]  fill_done_o;
    logic [15:0] line_addr_o;
    logic        busy_o;
    logic [1:0]  stall_o;

    always #5 clk = ~clk;

    cache_fill_ctrl #(
        .ADDR_W         (16),
        .DATA_W         (16),
        .WORDS_PER_LINE (4),
        .NUM_CH         (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .miss_i        (miss_i),
        .miss_addr_i   (miss_addr_i),
        .mem_data_i    (mem_data_i),
        .mem_valid_i   (mem_valid_i),
        .mem_en_o      (mem_en_o),
        .mem_addr_o    (mem_addr_o),
        .fill_data_o   (fill_data_o),
        .fill_offset_o (fill_offset_o),
        .fill_we_o     (fill_we_o),
        .fill_done_o   (fill_done_o),
        .line_addr_o   (line_addr_o),
        .busy_o        (busy_o),
        .stall_o       (stall_o)
    );

    typedef struct {
        logic [1:0]  miss;
        logic [15:0] a0;
        logic [15:0] a1;
        logic        en;
        logic [15:0] addr;
        logic [1:0]  we;
        logic [1:0]  off;
        logic [15:0] data;
        logic [1:0]  done;
        logic [15:0] line;
        logic        busy;
        logic [1:0]  stall;
    } vec_t;

    typedef struct {
        int          due;
        logic [15:0] addr;
    } rsp_t;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   req_idx = 0;
    int   lat_tab[4] = '{4, 4, 4, 4};
    bit   stray = 1'b0;
    rsp_t rsp_q[$];
    vec_t tab[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input vec_t e);
        chk({tag, ".mem_en"}, 32'(mem_en_o), 32'(e.en));
        if (e.en) chk({tag, ".mem_addr"}, 32'(mem_addr_o), 32'(e.addr));
        chk({tag, ".fill_we"}, 32'(fill_we_o), 32'(e.we));
        if (e.we != 2'b00) begin
            chk({tag, ".fill_off"}, 32'(fill_offset_o), 32'(e.off));
            chk({tag, ".fill_data"}, 32'(fill_data_o), 32'(e.data));
        end
        chk({tag, ".fill_done"}, 32'(fill_done_o), 32'(e.done));
        if (e.done != 2'b00) chk({tag, ".line_addr"}, 32'(line_addr_o), 32'(e.line));
        chk({tag, ".busy"}, 32'(busy_o), 32'(e.busy));
        chk({tag, ".stall"}, 32'(stall_o), 32'(e.stall));
    endtask

    // One clock: drive this cycle's memory response, then log any request at the negedge.
    task automatic tick();
        rsp_t r;
        @(posedge clk);
        cyc++;
        #1;
        mem_valid_i = 1'b0;
        mem_data_i  = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            mem_valid_i = 1'b1;
            mem_data_i  = rsp_q[0].addr;
            void'(rsp_q.pop_front());
        end else if (stray) begin
            mem_valid_i = 1'b1;
            mem_data_i  = 16'hBEEF;
        end
        @(negedge clk);
        if (mem_en_o) begin
            r.due  = cyc + lat_tab[req_idx % 4];
            r.addr = mem_addr_o;
            rsp_q.push_back(r);
            req_idx++;
        end
    endtask

    // Nominal latency-4 fill on channel ch whose first request lands in cycle s.
    function automatic vec_t std_exp(input int k, input int s, input int ch,
                                     input logic [15:0] base, input logic [1:0] miss);
        vec_t e;
        e = '{default: '0};
        e.miss = miss;
        if (k >= s && k < s + 4) begin
            e.en   = 1'b1;
            e.addr = base + 16'(2 * (k - s));
        end
        if (k >= s + 4 && k < s + 8) begin
            e.we[ch] = 1'b1;
            e.off    = 2'(k - s - 4);
            e.data   = base + 16'(2 * (k - s - 4));
        end
        if (k == s + 8) begin
            e.done[ch] = 1'b1;
            e.line     = base;
        end
        e.busy  = (k >= s && k <= s + 8);
        e.stall = miss & ~e.done;
        return e;
    endfunction

    initial begin
        vec_t e;
        vec_t z;
        int   we_cyc[4];
        z = '{default: '0};

        // Scenario 1 vectors: {miss, a0, a1, en, addr, we, off, data, done, line, busy, stall}
        tab[0] = '{2'b10, 16'h0, 16'h1236, 1'b1, 16'h1230, 2'b00, 2'd0, 16'h0, 2'b00, 16'h0, 1'b1, 2'b10};
        tab[1] = '{2'b10, 16'h0, 16'h1236, 1'b1, 16'h1232, 2'b00, 2'd0, 16'h0, 2'b00, 16'h0, 1'b1, 2'b10};
        tab[2] = '{2'b10, 16'h0, 16'h1236, 1'b1, 16'h1234, 2'b00, 2'd0, 16'h0, 2'b00, 16'h0, 1'b1, 2'b10};
        tab[3] = '{2'b10, 16'h0, 16'h1236, 1'b1, 16'h1236, 2'b00, 2'd0, 16'h0, 2'b00, 16'h0, 1'b1, 2'b10};
        tab[4] = '{2'b10, 16'h0, 16'h1236, 1'b0, 16'h0, 2'b10, 2'd0, 16'h1230, 2'b00, 16'h0, 1'b1, 2'b10};
        tab[5] = '{2'b10, 16'h0, 16'h1236, 1'b0, 16'h0, 2'b10, 2'd1, 16'h1232, 2'b00, 16'h0, 1'b1, 2'b10};
        tab[6] = '{2'b10, 16'h0, 16'h1236, 1'b0, 16'h0, 2'b10, 2'd2, 16'h1234, 2'b00, 16'h0, 1'b1, 2'b10};
        tab[7] = '{2'b10, 16'h0, 16'h1236, 1'b0, 16'h0, 2'b10, 2'd3, 16'h1236, 2'b00, 16'h0, 1'b1, 2'b10};
        tab[8] = '{2'b10, 16'h0, 16'h1236, 1'b0, 16'h0, 2'b00, 2'd0, 16'h0, 2'b10, 16'h1230, 1'b1, 2'b00};
        tab[9] = '{2'b00, 16'h0, 16'h0, 1'b0, 16'h0, 2'b00, 2'd0, 16'h0, 2'b00, 16'h0, 1'b0, 2'b00};

        // Reset state: outputs quiet, stall follows miss_i combinationally.
        #2;
        chk_vec("rst", z);
        miss_i = 2'b01;
        #1;
        e = z;
        e.stall = 2'b01;
        chk_vec("rst_stall", e);
        miss_i = 2'b00;
        tick();
        tick();
        rst_n = 1'b1;

        // 1: single miss, table-driven.
        for (int i = 0; i < 10; i++) begin
            miss_i      = tab[i].miss;
            miss_addr_i = {tab[i].a1, tab[i].a0};
            tick();
            chk_vec($sformatf("s1.c%0d", i + 1), tab[i]);
        end

        // 2: simultaneous misses, ch0 first, ch1 two cycles after ch0's done.
        miss_i      = 2'b11;
        miss_addr_i = {16'h2000, 16'h0040};
        for (int k = 1; k <= 20; k++) begin
            tick();
            e = (k <= 9) ? std_exp(k, 1, 0, 16'h0040, miss_i) : std_exp(k, 11, 1, 16'h2000, miss_i);
            chk_vec($sformatf("s2.c%0d", k), e);
            if (k == 9) miss_i[0] = 1'b0;
            if (k == 19) miss_i = 2'b00;
        end

        // 3: variable latency 1/3/5/7; first response arrives during REQ.
        lat_tab = '{1, 3, 5, 7};
        req_idx = 0;
        we_cyc  = '{2, 5, 8, 11};
        miss_i      = 2'b01;
        miss_addr_i = {16'h0, 16'h0100};
        for (int k = 1; k <= 13; k++) begin
            tick();
            e = '{default: '0};
            if (k <= 4) begin
                e.en   = 1'b1;
                e.addr = 16'h0100 + 16'(2 * (k - 1));
            end
            for (int j = 0; j < 4; j++) begin
                if (k == we_cyc[j]) begin
                    e.we   = 2'b01;
                    e.off  = 2'(j);
                    e.data = 16'h0100 + 16'(2 * j);
                end
            end
            if (k == 12) begin
                e.done = 2'b01;
                e.line = 16'h0100;
            end
            e.busy  = (k <= 12);
            e.stall = miss_i & ~e.done;
            chk_vec($sformatf("s3.c%0d", k), e);
            if (k == 12) miss_i = 2'b00;
        end
        lat_tab = '{4, 4, 4, 4};

        // 4: stray valid in IDLE and DONE; miss inputs change mid-fill.
        stray = 1'b1;
        tick();
        chk_vec("s4.idle_stray", z);
        stray       = 1'b0;
        miss_i      = 2'b01;
        miss_addr_i = {16'h0, 16'h0A0C};
        for (int k = 1; k <= 10; k++) begin
            tick();
            e = std_exp(k, 1, 0, 16'h0A08, miss_i);
            chk_vec($sformatf("s4.c%0d", k), e);
            if (k == 2) begin
                miss_i      = 2'b11;
                miss_addr_i = {16'h3000, 16'h7777};
            end
            if (k == 8) stray = 1'b1;
            if (k == 9) begin
                stray  = 1'b0;
                miss_i = 2'b00;
            end
        end

        // 5: reset mid-fill, then a fresh fill once released with miss still high.
        miss_i      = 2'b10;
        miss_addr_i = {16'h1236, 16'h0};
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk_vec($sformatf("s5.pre%0d", k), std_exp(k, 1, 1, 16'h1230, miss_i));
        end
        rst_n = 1'b0;
        #1;
        e = z;
        e.stall = 2'b10;
        chk_vec("s5.rst_now", e);
        chk("s5.rst_mem_addr", 32'(mem_addr_o), 32'h0);
        chk("s5.rst_fill_data", 32'(fill_data_o), 32'h0);
        chk("s5.rst_line_addr", 32'(line_addr_o), 32'h0);
        for (int k = 7; k <= 9; k++) begin
            tick();
            chk_vec($sformatf("s5.held%0d", k), e);
        end
        rst_n = 1'b1;
        for (int k = 10; k <= 19; k++) begin
            tick();
            chk_vec($sformatf("s5.c%0d", k), std_exp(k, 10, 1, 16'h1230, miss_i));
            if (k == 18) miss_i = 2'b00;
        end

        // 6: line at the top of the address space.
        miss_i      = 2'b01;
        miss_addr_i = {16'h0, 16'hFFFE};
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk_vec($sformatf("s6.c%0d", k), std_exp(k, 1, 0, 16'hFFF8, miss_i));
            if (k == 9) miss_i = 2'b00;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
